r_sync_ctrl: RTL
================

Name: r_sync_ctrl

Overview:
- Write-side steering and read-side watchdog controller for the 1x3 router, sitting between the router FSM, the three output FIFOs and the external readers.
- Latches the destination address, steers write enables and the full flag of the addressed FIFO, and presents per-port valid.
- Runs one read-timeout watchdog per output port. When a port's data goes unread for TIMEOUT cycles, the watchdog pulses that port's soft reset, which flushes the FIFO and returns the router FSM to address decode.

Parameters:
- TIMEOUT, 30: consecutive unread cycles (vld_out=1, read_enb=0) before soft_reset fires; legal range 2..31.
- CNT_W, 5: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- detect_addr  input  1  router FSM is in address-decode state; address is latched this cycle.
- data_in  input  2  header address bits; 0..2 select a port, 3 is invalid.
- write_enb_reg  input  1  router FSM write strobe.
- read_enb  input  3  per-port read strobe from the external readers.
- empty  input  3  per-port FIFO empty.
- full  input  3  per-port FIFO full.
- write_enb  output  3  one-hot FIFO write enable.
- fifo_full  output  1  full flag of the addressed FIFO.
- vld_out  output  3  per-port data valid.
- soft_reset  output  3  per-port one-cycle flush pulse, registered.

Behaviour:
- addr_reg (2b), reset value 2'b11 (ADDR_NONE). Next-edge update priority:
  - any soft_reset bit high -> ADDR_NONE;
  - else detect_addr -> data_in;
  - else hold.
- write_enb[i] = write_enb_reg && addr_reg==i, combinational. All zero when addr_reg is ADDR_NONE.
- fifo_full = full[addr_reg], combinational; 0 when addr_reg is ADDR_NONE.
- vld_out[i] = ~empty[i], combinational.
- Reset values: soft_reset=0, all counters 0, all watchdogs IDLE. The combinational outputs follow their inputs with addr_reg=ADDR_NONE.
- Each watchdog is independent. Signals: v=vld_out[i], r=read_enb[i].
  - IDLE: v&!r -> COUNT, cnt=1; otherwise stay, cnt=0.
  - COUNT, transitions in priority order:
    - r -> IDLE, cnt=0;
    - !v -> IDLE, cnt=0;
    - v&!r and cnt==TIMEOUT-1 -> FIRE, cnt=0;
    - otherwise cnt+1.
  - FIRE: soft_reset[i]=1 for exactly this cycle; unconditional -> IDLE; inputs ignored.
  - soft_reset[i] is decoded from the registered state, so it rises on the edge after the TIMEOUT-th consecutive unread cycle.
- Boundary conditions:
  - A read in the same cycle that would hit the threshold wins; no fire.
  - If the FIFO is still non-empty after FIRE, counting restarts from IDLE, so a new fire occurs at the earliest TIMEOUT+1 cycles later.
  - Counter never wraps; it saturates by construction through FIRE.
  - Simultaneous fires on several ports are allowed. Each port pulses independently and addr_reg clears once.
  - A soft_reset on a non-addressed port still clears addr_reg. This matches the router FSM, which returns to decode on any soft reset.
  - Asynchronous reset mid-count or mid-FIRE clears everything immediately; soft_reset drops without completing its pulse.

Optional Feature:
- Macro: R_SYNC_STATUS_EN.
- Defined:
  - Adds input clr_status (1) and output timeout_flag (3).
  - timeout_flag[i] is sticky. Set on the edge where that watchdog enters FIRE, cleared by clr_status on the next edge; set wins if both occur together. Reset value 0.
- Undefined: neither port exists, and no status logic is generated.

Decomposition:
- Package r_pkg holds:
  - ADDR_NONE=2'b11;
  - port index constants P0/P1/P2;
  - watchdog state encoding IDLE=2'b00, COUNT=2'b01, FIRE=2'b10.
- Sub-module r_port_wdog, parameterised by TIMEOUT/CNT_W. Ports clk, rst, vld, rd, soft_reset (plus fired when R_SYNC_STATUS_EN is defined). Instantiated three times.
- Address latch, steering and status logic live in the top level.

Test Plan:
- Reset, then detect_addr=1 with data_in=1 for one cycle, then write_enb_reg=1 -> write_enb=3'b010 and fifo_full=full[1]. With data_in=3: write_enb=0, fifo_full=0.
- empty[0]=0, read_enb[0]=0 held -> soft_reset[0] high exactly one cycle, starting on the edge after 30 unread cycles. addr_reg becomes 3 on the following edge.
- empty[2]=0, read_enb[2] pulsed at unread cycle 29 (0-based), then held low -> no fire at 30; the next fire comes 30 cycles after the read cycle.
- Read on exactly the threshold cycle (cnt==29, r=1) -> no soft_reset, watchdog returns to IDLE.
- Ports 0 and 1 start unread in the same cycle -> both soft_reset bits pulse together, one cycle wide. rst asserted low mid-count on port 2 -> counter clears immediately and there is no later fire.
- With R_SYNC_STATUS_EN defined: port 1 times out -> timeout_flag=3'b010 persists. clr_status in the same cycle a new FIRE is entered -> flag stays set.

Source files
------------

// File: rtl/r_sync_ctrl_pkg.sv
// r_pkg: shared constants and watchdog state encoding for the r_sync_ctrl
// write-steering / read-watchdog block. Optional status logic elsewhere in
// this slice is enabled with the R_SYNC_STATUS_EN macro.
package r_pkg;

  // Address register value meaning "no port selected"
  localparam logic [1:0] ADDR_NONE = 2'b11;

  // Output port indices
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;

  // Per-port read watchdog states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    FIRE  = 2'b10
  } wdog_state_t;

endpackage

// File: rtl/r_sync_ctrl_if.sv
// r_sync_ctrl_if: bundles the router-FSM, FIFO and reader signals seen by
// r_sync_ctrl. The clr_status/timeout_flag pair exists only when
// R_SYNC_STATUS_EN is defined.
interface r_sync_ctrl_if;

  logic       detect_addr;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] read_enb;
  logic [2:0] empty;
  logic [2:0] full;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
`ifdef R_SYNC_STATUS_EN
  logic       clr_status;
  logic [2:0] timeout_flag;
`endif

  // Controller side
  modport slave (
    input  detect_addr, data_in, write_enb_reg, read_enb, empty, full,
    output write_enb, fifo_full, vld_out, soft_reset
`ifdef R_SYNC_STATUS_EN
    , input clr_status
    , output timeout_flag
`endif
  );

  // Environment side (router FSM, FIFOs, readers)
  modport master (
    output detect_addr, data_in, write_enb_reg, read_enb, empty, full,
    input  write_enb, fifo_full, vld_out, soft_reset
`ifdef R_SYNC_STATUS_EN
    , output clr_status
    , input timeout_flag
`endif
  );

endinterface

// File: rtl/r_sync_ctrl_wdog.sv
// r_port_wdog: read-timeout watchdog for one output port. Counts consecutive
// cycles with valid data and no read; after TIMEOUT such cycles it spends one
// cycle in FIRE, which drives the registered soft reset pulse.
// o_fired (entry into FIRE) exists only when R_SYNC_STATUS_EN is defined.
module r_port_wdog
  import r_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  input  logic i_rd,
  output logic o_soft_reset
`ifdef R_SYNC_STATUS_EN
  , output logic o_fired
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  wdog_state_t      r_state;
  wdog_state_t      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_unread;

  assign w_unread = i_vld & ~i_rd;

  // State and counter registers; async reset abandons any pending pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state: a read beats the threshold, FIRE always lasts one cycle
  always_comb begin
    w_state_next = IDLE;
    w_cnt_next   = '0;
    case (r_state)
      IDLE: begin
        if (w_unread) begin
          w_state_next = COUNT;
          w_cnt_next   = CNT_W'(1);
        end
      end
      COUNT: begin
        if (i_rd || !i_vld) begin
          w_state_next = IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_state_next = FIRE;
        end else begin
          w_state_next = COUNT;
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_soft_reset = (r_state == FIRE);

`ifdef R_SYNC_STATUS_EN
  assign o_fired = (w_state_next == FIRE);
`endif

endmodule

// File: rtl/r_sync_ctrl.sv
// r_sync_ctrl: latches the router destination address, steers FIFO write
// enables and the addressed full flag, and runs one read watchdog per port.
// Define R_SYNC_STATUS_EN to add sticky per-port timeout flags.
module r_sync_ctrl
  import r_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input logic          clk,
  input logic          rst,
  r_sync_ctrl_if.slave bus
);

  logic [1:0] r_addr;
  logic [2:0] w_vld;
  logic [2:0] w_soft_reset;
  logic [2:0] w_write_enb;
  logic       w_fifo_full;
`ifdef R_SYNC_STATUS_EN
  logic [2:0] w_fired;
  logic [2:0] r_timeout_flag;
`endif

  assign w_vld          = ~bus.empty;
  assign bus.vld_out    = w_vld;
  assign bus.soft_reset = w_soft_reset;
  assign bus.write_enb  = w_write_enb;
  assign bus.fifo_full  = w_fifo_full;

  for (genvar gi = 0; gi < 3; gi++) begin : g_wdog
    r_port_wdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_wdog (
      .clk          (clk),
      .rst          (rst),
      .i_vld        (w_vld[gi]),
      .i_rd         (bus.read_enb[gi]),
      .o_soft_reset (w_soft_reset[gi])
`ifdef R_SYNC_STATUS_EN
      , .o_fired    (w_fired[gi])
`endif
    );
  end

  // Address latch: any port's soft reset sends the router back to decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= ADDR_NONE;
    end else if (|w_soft_reset) begin
      r_addr <= ADDR_NONE;
    end else if (bus.detect_addr) begin
      r_addr <= bus.data_in;
    end
  end

  // Steer the write strobe and full flag of the currently addressed FIFO
  always_comb begin
    w_write_enb = 3'b000;
    w_fifo_full = 1'b0;
    case (r_addr)
      P0: begin
        w_write_enb = {2'b00, bus.write_enb_reg};
        w_fifo_full = bus.full[0];
      end
      P1: begin
        w_write_enb = {1'b0, bus.write_enb_reg, 1'b0};
        w_fifo_full = bus.full[1];
      end
      P2: begin
        w_write_enb = {bus.write_enb_reg, 2'b00};
        w_fifo_full = bus.full[2];
      end
      default: begin
        w_write_enb = 3'b000;
        w_fifo_full = 1'b0;
      end
    endcase
  end

`ifdef R_SYNC_STATUS_EN
  // Sticky timeout flags: a new fire wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout_flag <= '0;
    end else begin
      r_timeout_flag <= (r_timeout_flag & ~{3{bus.clr_status}}) | w_fired;
    end
  end

  assign bus.timeout_flag = r_timeout_flag;
`endif

endmodule
